// File: rtl/pea_11_ctrl_pkg.sv
// Shared types for the 1x1-conv PE array sequencer: FSM state encoding,
// latched tile configuration and the all-columns-valid mask.
package pea_11_ctrl_pkg;

  localparam int PEA_COL       = 8;
  localparam int PEA_IC_W      = 8;
  localparam int PEA_OC_W      = 8;
  localparam int PEA_RF_AWIDTH = 4;

  localparam logic [PEA_COL-1:0] MASK_ALL = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FIN    = 3'd4
  } ctrl_state_e;

  // Field widths follow the package defaults; top-level overrides must match.
  typedef struct packed {
    logic [PEA_IC_W-1:0]      ic_m1;
    logic [PEA_OC_W-1:0]      oc_m1;
    logic [PEA_RF_AWIDTH-1:0] pix_m1;
    logic [PEA_COL-1:0]       last_mask;
    logic                     stride;
  } pea_cfg_t;

endpackage

// File: rtl/pea_11_vld_pipe.sv
// Fixed-latency delay line that carries {mask, ic_last, oc_last} alongside
// each accepted ifm beat, so the flags line up with the PE outputs.
module pea_11_vld_pipe #(
  parameter int W     = 10,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] stage_q;
  logic [DEPTH-1:0][W-1:0] stage_d;

  // Cycles without an accepted beat inject zeros, which becomes pvalid = 0.
  assign stage_d[0] = en ? din : '0;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_stage
      assign stage_d[gi] = stage_q[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/pea_11_ctrl.sv
// Tile sequencer for the 1x1-conv PE array: walks oc (outer), ic (middle),
// pixel groups (inner), pops weights/ifm groups and aligns psum-valid flags.
module pea_11_ctrl
  import pea_11_ctrl_pkg::*;
#(
  parameter int COL       = PEA_COL,
  parameter int PE_LAT    = 2,
  parameter int IC_W      = PEA_IC_W,
  parameter int OC_W      = PEA_OC_W,
  parameter int RF_AWIDTH = PEA_RF_AWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IC_W-1:0]      cfg_ic_m1,
  input  logic [OC_W-1:0]      cfg_oc_m1,
  input  logic [RF_AWIDTH-1:0] cfg_pix_m1,
  input  logic [COL-1:0]       cfg_last_mask,
  input  logic                 cfg_stride,
  output logic                 busy,
  output logic                 done,
  input  logic                 wgt_valid,
  output logic                 wgt_read,
  input  logic                 ifm_valid,
  output logic                 ifm_read,
  output logic                 stride,
  output logic [COL-1:0]       pvalid,
  output logic                 ic_done,
  output logic                 oc_done
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_LOAD_W = ST_LOAD_W;
  localparam logic [2:0] S_STREAM = ST_STREAM;
  localparam logic [2:0] S_DRAIN  = ST_DRAIN;
  localparam logic [2:0] S_FIN    = ST_FIN;

  localparam int DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

  logic [2:0]           state_q, state_d;
  pea_cfg_t             cfg_q, cfg_d;
  logic [IC_W-1:0]      ic_q, ic_d;
  logic [OC_W-1:0]      oc_q, oc_d;
  logic [RF_AWIDTH-1:0] pix_q, pix_d;
  logic [DW-1:0]        drain_q, drain_d;

  logic pix_last, ic_last, oc_last;
  logic [COL+1:0] pipe_in, pipe_out;

  assign pix_last = (pix_q == cfg_q.pix_m1);
  assign ic_last  = (ic_q == cfg_q.ic_m1);
  assign oc_last  = (oc_q == cfg_q.oc_m1);

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    ic_d     = ic_q;
    oc_d     = oc_q;
    pix_d    = pix_q;
    drain_d  = drain_q;
    wgt_read = 1'b0;
    ifm_read = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cfg_d.ic_m1     = cfg_ic_m1;
          cfg_d.oc_m1     = cfg_oc_m1;
          cfg_d.pix_m1    = cfg_pix_m1;
          cfg_d.last_mask = cfg_last_mask;
          cfg_d.stride    = cfg_stride;
          ic_d            = '0;
          oc_d            = '0;
          pix_d           = '0;
          state_d         = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        wgt_read = wgt_valid;
        if (wgt_valid) state_d = S_STREAM;
      end
      S_STREAM: begin
        ifm_read = ifm_valid;
        if (ifm_valid) begin
          if (pix_last) begin
            // Leaving STREAM here guarantees a bubble before the next weight lands.
            pix_d = '0;
            if (!ic_last) begin
              ic_d    = ic_q + IC_W'(1);
              state_d = S_LOAD_W;
            end else if (!oc_last) begin
              ic_d    = '0;
              oc_d    = oc_q + OC_W'(1);
              state_d = S_LOAD_W;
            end else begin
              drain_d = '0;
              state_d = S_DRAIN;
            end
          end else begin
            pix_d = pix_q + RF_AWIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(PE_LAT - 1)) state_d = S_FIN;
        else                            drain_d = drain_q + DW'(1);
      end
      S_FIN: begin
        cfg_d.stride = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      ic_q    <= '0;
      oc_q    <= '0;
      pix_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      ic_q    <= ic_d;
      oc_q    <= oc_d;
      pix_q   <= pix_d;
      drain_q <= drain_d;
    end
  end

  assign busy   = (state_q == S_LOAD_W) || (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign done   = (state_q == S_FIN);
  assign stride = cfg_q.stride;

  assign pipe_in = {(pix_last ? cfg_q.last_mask : MASK_ALL),
                    pix_last & ic_last,
                    pix_last & ic_last & oc_last};

  pea_11_vld_pipe #(
    .W     (COL + 2),
    .DEPTH (PE_LAT)
  ) u_vld_pipe (
    .clk  (clk),
    .rst  (rst),
    .en   (ifm_read),
    .din  (pipe_in),
    .dout (pipe_out)
  );

  assign pvalid  = pipe_out[COL+1:2];
  assign ic_done = pipe_out[1];
  assign oc_done = pipe_out[0];

endmodule

// File: tb/tb_pea_11_ctrl.sv
// Directed bench for pea_11_ctrl: tile runs with hand-computed strobe counts,
// latencies, stall, mid-tile reset and start-while-busy scenarios.
module tb_pea_11_ctrl;

  localparam int COL       = 8;
  localparam int PE_LAT    = 2;
  localparam int IC_W      = 8;
  localparam int OC_W      = 8;
  localparam int RF_AWIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [IC_W-1:0]      cfg_ic_m1 = '0;
  logic [OC_W-1:0]      cfg_oc_m1 = '0;
  logic [RF_AWIDTH-1:0] cfg_pix_m1 = '0;
  logic [COL-1:0]       cfg_last_mask = '0;
  logic                 cfg_stride = 1'b0;
  logic                 wgt_valid = 1'b0;
  logic                 ifm_valid = 1'b0;
  logic                 busy, done, wgt_read, ifm_read, stride, ic_done, oc_done;
  logic [COL-1:0]       pvalid;

  always #5 clk = ~clk;

  pea_11_ctrl #(
    .COL(COL), .PE_LAT(PE_LAT), .IC_W(IC_W), .OC_W(OC_W), .RF_AWIDTH(RF_AWIDTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_ic_m1(cfg_ic_m1), .cfg_oc_m1(cfg_oc_m1), .cfg_pix_m1(cfg_pix_m1),
    .cfg_last_mask(cfg_last_mask), .cfg_stride(cfg_stride),
    .busy(busy), .done(done),
    .wgt_valid(wgt_valid), .wgt_read(wgt_read),
    .ifm_valid(ifm_valid), .ifm_read(ifm_read),
    .stride(stride), .pvalid(pvalid), .ic_done(ic_done), .oc_done(oc_done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Per-tile monitor, cleared on an accepted start; samples on the falling edge.
  int tcyc, n_wgt, n_ifm, n_pvff, n_pv0f, n_pvbad, n_icd, n_ocd, n_done;
  int n_lag, n_ovl, n_ocbad, ocd_icd, first_wgt, first_ifm, first_pv, first_pv_val;
  int done_cyc, stride_at_done, busy_nostride;
  logic [PE_LAT-1:0] ifm_hist = '0;

  always @(negedge clk) begin
    if (start && !busy && !rst) begin
      tcyc = 0; n_wgt = 0; n_ifm = 0; n_pvff = 0; n_pv0f = 0; n_pvbad = 0;
      n_icd = 0; n_ocd = 0; n_done = 0; n_lag = 0; n_ovl = 0; n_ocbad = 0;
      ocd_icd = -1; first_wgt = -1; first_ifm = -1; first_pv = -1;
      first_pv_val = -1; done_cyc = -1; stride_at_done = -1; busy_nostride = 0;
    end else begin
      tcyc++;
    end
    if (wgt_read) begin n_wgt++; if (first_wgt < 0) first_wgt = tcyc; end
    if (ifm_read) begin n_ifm++; if (first_ifm < 0) first_ifm = tcyc; end
    if (wgt_read && ifm_read) n_ovl++;
    if ((pvalid != '0) != ifm_hist[PE_LAT-1]) n_lag++;
    if (pvalid == 8'hFF) n_pvff++;
    else if (pvalid == 8'h0F) n_pv0f++;
    else if (pvalid != 8'h00) n_pvbad++;
    if (pvalid != '0 && first_pv < 0) begin
      first_pv = tcyc;
      first_pv_val = int'({pvalid, ic_done, oc_done});
    end
    if (ic_done) n_icd++;
    if (oc_done) begin n_ocd++; ocd_icd = n_icd; if (!ic_done) n_ocbad++; end
    if (done) begin n_done++; done_cyc = tcyc; stride_at_done = int'(stride); end
    if (busy && !stride) busy_nostride++;
    ifm_hist = rst ? '0 : {ifm_hist[PE_LAT-2:0], ifm_read};
  end

  task automatic run_tile(input int ic, input int oc, input int pix, input logic [7:0] mask,
                          input logic strd, input bit rnd, input int whold, input int extra);
    bit seen;
    seen = 1'b0;
    @(posedge clk); #1;
    cfg_ic_m1 = IC_W'(ic); cfg_oc_m1 = OC_W'(oc); cfg_pix_m1 = RF_AWIDTH'(pix);
    cfg_last_mask = mask; cfg_stride = strd;
    start = 1'b1; wgt_valid = (whold > 0) ? 1'b0 : 1'b1; ifm_valid = 1'b1;
    for (int t = 1; t <= 600 && !seen; t++) begin
      @(posedge clk); #1;
      start = (t == extra);
      if (t == extra) begin
        cfg_ic_m1 = '0; cfg_oc_m1 = '0; cfg_pix_m1 = '0; cfg_last_mask = 8'h01; cfg_stride = 1'b0;
      end
      wgt_valid = (t <= whold) ? 1'b0 : 1'b1;
      ifm_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      seen = done;
    end
    chk("tile_done_seen", 32'(seen), 1);
    @(posedge clk); #1;
    start = 1'b0; ifm_valid = 1'b1; wgt_valid = 1'b1;
    @(negedge clk); #1;
  endtask

  initial begin
    int pv_after;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {busy, done, wgt_read, ifm_read, stride, ic_done, oc_done}, 0);
    chk("rst_pvalid", pvalid, 0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: degenerate tile
    run_tile(0, 0, 0, 8'hFF, 1'b0, 1'b0, 0, -1);
    chk("t1_wgt_cnt", n_wgt, 1);
    chk("t1_ifm_cnt", n_ifm, 1);
    chk("t1_wgt_cyc", first_wgt, 1);
    chk("t1_ifm_cyc", first_ifm, 2);
    chk("t1_pv_cyc", first_pv, 2 + PE_LAT);
    chk("t1_pv_val", first_pv_val, 32'h3FF);
    chk("t1_done_cyc", done_cyc, 2 + PE_LAT + 1);
    chk("t1_done_cnt", n_done, 1);
    chk("t1_busy_after", busy, 0);

    // 2: 3 ic x 2 oc x 4 pixel groups, valids high
    run_tile(2, 1, 3, 8'h0F, 1'b0, 1'b0, 0, -1);
    chk("t2_wgt_cnt", n_wgt, 6);
    chk("t2_ifm_cnt", n_ifm, 24);
    chk("t2_icd_cnt", n_icd, 2);
    chk("t2_ocd_cnt", n_ocd, 1);
    chk("t2_ocd_at_icd", ocd_icd, 2);
    chk("t2_ocd_noicd", n_ocbad, 0);
    chk("t2_pv0f_cnt", n_pv0f, 6);
    chk("t2_pvff_cnt", n_pvff, 18);
    chk("t2_pvbad_cnt", n_pvbad, 0);
    chk("t2_lag_err", n_lag, 0);

    // 3: same tile with random ifm stalls
    run_tile(2, 1, 3, 8'h0F, 1'b0, 1'b1, 0, -1);
    chk("t3_wgt_cnt", n_wgt, 6);
    chk("t3_ifm_cnt", n_ifm, 24);
    chk("t3_icd_cnt", n_icd, 2);
    chk("t3_ocd_cnt", n_ocd, 1);
    chk("t3_pv0f_cnt", n_pv0f, 6);
    chk("t3_lag_err", n_lag, 0);
    chk("t3_wgt_ifm_ovl", n_ovl, 0);

    // 4: weight buffer empty for 5 cycles in LOAD_W
    run_tile(2, 1, 3, 8'h0F, 1'b0, 1'b0, 5, -1);
    chk("t4_wgt_cyc", first_wgt, 6);
    chk("t4_ifm_cyc", first_ifm, 7);
    chk("t4_wgt_cnt", n_wgt, 6);
    chk("t4_ifm_cnt", n_ifm, 24);

    // 5: reset mid-STREAM
    @(posedge clk); #1;
    cfg_ic_m1 = 2; cfg_oc_m1 = 1; cfg_pix_m1 = 3; cfg_last_mask = 8'h0F; cfg_stride = 1'b1;
    start = 1'b1; wgt_valid = 1'b1; ifm_valid = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    chk("t5_pre_busy", busy, 1);
    chk("t5_pre_pv", 32'(pvalid != '0), 1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("t5_post_ctl", {busy, done, wgt_read, ifm_read, stride, ic_done, oc_done}, 0);
    chk("t5_post_pv", pvalid, 0);
    pv_after = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (pvalid != '0 || done) pv_after++;
    end
    chk("t5_flush", pv_after, 0);
    chk("t5_no_done", n_done, 0);
    run_tile(2, 1, 3, 8'h0F, 1'b0, 1'b0, 0, -1);
    chk("t5_re_wgt_cnt", n_wgt, 6);
    chk("t5_re_ifm_cnt", n_ifm, 24);
    chk("t5_re_ocd_cnt", n_ocd, 1);

    // 6: stride tile with a second start while busy
    run_tile(2, 1, 3, 8'h0F, 1'b1, 1'b0, 0, 5);
    chk("t6_stride_done", stride_at_done, 1);
    chk("t6_stride_busy", busy_nostride, 0);
    chk("t6_stride_after", stride, 0);
    chk("t6_wgt_cnt", n_wgt, 6);
    chk("t6_ifm_cnt", n_ifm, 24);
    repeat (5) @(negedge clk);
    chk("t6_done_cnt", n_done, 1);
    chk("t6_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
